// File: rtl/bcd_game_pkg.sv
// Shared types and defaults for the push-button conditioning logic.
// Holds the per-channel FSM state encoding, default timing constants and a
// small integer helper used to size the shared debounce/repeat counter.
package bcd_game_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } btn_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
  localparam int DEFAULT_REPEAT_CYCLES   = 64;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// Purpose: one button channel -- 2-flop synchronizer, debounce FSM, strobe.
// Latency: press strobe 2+DEBOUNCE_CYCLES cycles after first low sample.
// Backpressure: none; strobe is a single-cycle event with no handshake.
//
// Ports:
//   clk       - rising-edge clock
//   reset     - synchronous active-high reset
//   i_btn_n   - raw asynchronous button, 0 = pressed
//   o_pulse_n - registered active-low one-cycle strobe per accepted press
//   o_pressed - active-high debounced held level
// Optional feature: define BTN_HOLD_REPEAT_EN for auto-repeat strobes while held.
module btn_channel
  import bcd_game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn_n,
  output logic o_pulse_n,
  output logic o_pressed
);

  // One counter serves both debounce and repeat timing, so it is sized for
  // the larger of the two intervals.
  localparam int CNT_MAX = max_int(DEBOUNCE_CYCLES, REPEAT_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_MAX);
`ifdef BTN_HOLD_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

  logic             r_sync1;
  logic             r_sync2;
  btn_state_t       r_state;
  btn_state_t       w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_fire;
  logic             r_pulse_n;
  logic             w_pressed;
  logic             w_low;

  // Synchronizer idles high (released) so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_low = ~r_sync2;

  // Saturating increment: the counter sticks at its maximum rather than wrap.
  assign w_cnt_inc = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + 1'b1;

  // State register; the strobe is registered so it lands on the edge that
  // enters HELD and lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_pulse_n <= 1'b1;
    end else begin
      r_state   <= w_next_state;
      r_cnt     <= w_cnt_next;
      r_pulse_n <= ~w_fire;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_fire       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_low) begin
          w_next_state = DEB_PRESS;
          w_cnt_next   = '0;
        end
      end
      DEB_PRESS: begin
        if (!w_low) begin
          w_next_state = IDLE;
        end else if (r_cnt == DEB_LAST) begin
          w_next_state = HELD;
          w_cnt_next   = '0;
          w_fire       = 1'b1;
        end else begin
          w_cnt_next   = w_cnt_inc;
        end
      end
      HELD: begin
        if (!w_low) begin
          w_next_state = DEB_RELEASE;
          w_cnt_next   = '0;
        end
`ifdef BTN_HOLD_REPEAT_EN
        // Counter starts at 0 on the initial strobe, so repeats fall every
        // REPEAT_CYCLES after it.
        else if (r_cnt == REP_LAST) begin
          w_cnt_next = '0;
          w_fire     = 1'b1;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
`endif
      end
      DEB_RELEASE: begin
        if (w_low) begin
          // Release glitch: back to HELD silently; the repeat timer restarts
          // because the counter was borrowed for release debounce.
          w_next_state = HELD;
          w_cnt_next   = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_next_state = IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next   = w_cnt_inc;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Outputs: held level is a pure decode of state.
  always_comb begin
    w_pressed = (r_state == HELD) || (r_state == DEB_RELEASE);
  end

  assign o_pulse_n = r_pulse_n;
  assign o_pressed = w_pressed;

endmodule

// File: rtl/button_conditioner.sv
// Purpose: debounce NUM_BTN raw active-low buttons into strobes and levels.
// Latency: press strobe 2+DEBOUNCE_CYCLES cycles after first low sample.
// Backpressure: none; outputs are free-running strobes/levels.
//
// Ports:
//   clk     - rising-edge clock
//   reset   - synchronous active-high reset
//   btn_n   - [NUM_BTN] raw asynchronous buttons, 0 = pressed
//   pulse_n - [NUM_BTN] active-low one-cycle strobe per accepted press
//   pressed - [NUM_BTN] active-high debounced held level
// Optional feature: define BTN_HOLD_REPEAT_EN for auto-repeat strobes while held.
module button_conditioner
  import bcd_game_pkg::*;
#(
  parameter int NUM_BTN         = 3,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_n,
  output logic [NUM_BTN-1:0] pulse_n,
  output logic [NUM_BTN-1:0] pressed
);

  // Channels share nothing but clock and reset.
  for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
    btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .i_btn_n   (btn_n[g]),
      .o_pulse_n (pulse_n[g]),
      .o_pressed (pressed[g])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner. Expected strobes are queued with the
// clock edge they must appear after; a monitor matches every observed strobe.
module tb_button_conditioner;

  localparam int DEB = 16;
  localparam int REP = 64;
  localparam int LAT = 2 + DEB;

  typedef struct {
    int ch;
    int edge_n;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [2:0] btn_n;
  logic [2:0] pulse_n;
  logic [2:0] pressed;

  int   edge_cnt = 0;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];

  button_conditioner #(
    .NUM_BTN         (3),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_n   (btn_n),
    .pulse_n (pulse_n),
    .pressed (pressed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit, wanted completion");
    $fatal(1);
  end

  task automatic expect_pulse(input int ch, input int e);
    exp_t x;
    x.ch     = ch;
    x.edge_n = e;
    sb_q.push_back(x);
  endtask

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b, wanted %b (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int k;
  int idx;

  initial begin
    reset = 1'b1;
    btn_n = 3'b111;

    // Monitor: every low strobe bit must match the oldest queued entry for
    // that channel, at exactly the queued edge.
    fork
      forever begin
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
          if (pulse_n[c] === 1'b0) begin
            idx = -1;
            for (int i = 0; i < sb_q.size(); i++)
              if (idx < 0 && sb_q[i].ch == c) idx = i;
            checks++;
            if (idx < 0) begin
              failures++;
              $display("FAIL unexpected_pulse: ch %0d low at edge %0d, wanted none", c, edge_cnt);
            end else begin
              if (sb_q[idx].edge_n != edge_cnt) begin
                failures++;
                $display("FAIL pulse_time: ch %0d low at edge %0d, wanted edge %0d",
                         c, edge_cnt, sb_q[idx].edge_n);
              end
              sb_q.delete(idx);
            end
          end
        end
      end
    join_none

    // Reset state
    cyc(3);
    chk("reset_pulse_n", pulse_n, 3'b111);
    chk("reset_pressed", pressed, 3'b000);
    reset = 1'b0;
    cyc(5);

    // Clean press on ch0, 40 cycles
    k = edge_cnt;
    btn_n[0] = 1'b0;
    expect_pulse(0, k + LAT + 1);
    cyc(LAT);
    chk("clean_pressed_early", pressed, 3'b000);
    cyc(1);
    chk("clean_pressed_set", pressed, 3'b001);
    cyc(21);
    btn_n[0] = 1'b1;
    cyc(LAT);
    chk("clean_release_hold", pressed, 3'b001);
    cyc(1);
    chk("clean_release_clr", pressed, 3'b000);
    cyc(5);

    // Bounce on ch1: toggles every 5 cycles for 60 cycles
    for (int t = 0; t < 12; t++) begin
      btn_n[1] = (t % 2) != 0;
      cyc(5);
      chk("bounce_pressed", pressed, 3'b000);
    end
    btn_n[1] = 1'b1;
    cyc(25);
    chk("bounce_final", pressed, 3'b000);

    // Simultaneous presses
    k = edge_cnt;
    btn_n = 3'b000;
    for (int c = 0; c < 3; c++) expect_pulse(c, k + LAT + 1);
    cyc(LAT + 1);
    chk("simul_pulse", pulse_n, 3'b000);
    cyc(1);
    chk("simul_after", pulse_n, 3'b111);
    chk("simul_pressed", pressed, 3'b111);
    cyc(10);
    btn_n = 3'b111;
    cyc(LAT + 2);
    chk("simul_release", pressed, 3'b000);

    // Reset at cycle 10 of a press, button kept held
    btn_n[0] = 1'b0;
    cyc(10);
    reset = 1'b1;
    cyc(2);
    chk("rst_mid_pulse_n", pulse_n, 3'b111);
    chk("rst_mid_pressed", pressed, 3'b000);
    cyc(12);
    chk("rst_late_pressed", pressed, 3'b000);
    reset = 1'b0;
    k = edge_cnt;
    expect_pulse(0, k + LAT + 1);
    cyc(LAT);
    chk("rst_redeb_early", pressed, 3'b000);
    cyc(1);
    chk("rst_redeb_set", pressed, 3'b001);
    cyc(5);
    btn_n[0] = 1'b1;
    cyc(LAT + 2);
    chk("rst_release", pressed, 3'b000);

    // 3-cycle release glitch on ch1 while held
    k = edge_cnt;
    btn_n[1] = 1'b0;
    expect_pulse(1, k + LAT + 1);
    cyc(30);
    btn_n[1] = 1'b1;
    cyc(3);
    btn_n[1] = 1'b0;
    for (int t = 0; t < 12; t++) begin
      cyc(1);
      chk("glitch_pressed", pressed, 3'b010);
    end
    btn_n[1] = 1'b1;
    cyc(LAT + 2);
    chk("glitch_release", pressed, 3'b000);

    // Long hold on ch2: repeats only when the feature is built in
    k = edge_cnt;
    btn_n[2] = 1'b0;
    expect_pulse(2, k + LAT + 1);
`ifdef BTN_HOLD_REPEAT_EN
    expect_pulse(2, k + LAT + 1 + REP);
    expect_pulse(2, k + LAT + 1 + 2 * REP);
`endif
    cyc(200);
    chk("hold_pressed", pressed, 3'b100);
    btn_n[2] = 1'b1;
    cyc(LAT + 2);
    chk("hold_release", pressed, 3'b000);

    // Every queued strobe must have been seen
    cyc(10);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      foreach (sb_q[i])
        $display("FAIL missing_pulse: ch %0d never low, wanted at edge %0d",
                 sb_q[i].ch, sb_q[i].edge_n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
